// File: rtl/mcse_pkg.sv
// mcse_pkg
// Shared types for the MCSE scan-authentication controller:
//   mcse_state_e  - controller state encoding
//   mcse_result_e - outcome of one authentication attempt
//   clog2_min1    - $clog2 that never returns a zero width

package mcse_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      RESULT  = 2'd2,
      LOCKOUT = 2'd3
   } mcse_state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_PASS = 2'd1,
      RES_FAIL = 2'd2
   } mcse_result_e;

   // Index widths for single-entry structures still need one bit
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/mcse_ct_compare.sv
// mcse_ct_compare
// Serial constant-time comparator. Each enabled cycle folds the
// difference of one slice pair into a sticky mismatch flag; the flag
// never short-circuits, so the attempt length is independent of where
// (or whether) the keys differ.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - zero the accumulated flag (takes priority over en)
//   en         - accumulate the current slice pair
//   a, b       - slice pair under comparison
//   mismatch   - accumulated flag, 1 if any compared slice differed

module mcse_ct_compare #(
   parameter int CMP_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [CMP_W-1:0] a,
   input  logic [CMP_W-1:0] b,
   output logic             mismatch
);

   // The XOR-reduce is evaluated on every enabled cycle regardless of the
   // running flag so that timing and switching do not depend on key data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (clear) begin
         mismatch <= 1'b0;
      end else if (en) begin
         mismatch <= mismatch | (|(a ^ b));
      end
   end

endmodule

// File: rtl/mcse_def.svh
// mcse_def.svh
// Default parameter values shared by the MCSE scan-authentication blocks.
// Kept in one place so that integration and the block agree on the
// key geometry, attempt limit and timer lengths.

`ifndef MCSE_DEF_SVH
`define MCSE_DEF_SVH

`define MCSE_KEY_WIDTH      128
`define MCSE_NUM_CHAN       4
`define MCSE_CMP_W          32
`define MCSE_MAX_ATTEMPTS   3
`define MCSE_LOCKOUT_CYCLES 1024
`define MCSE_UNLOCK_TIMEOUT 0

`endif

// File: rtl/mcse_scan_auth_ctrl.sv
// mcse_scan_auth_ctrl
// Scan-unlock authentication controller. A candidate key is compared to
// the golden key of the selected channel in fixed-length serial fashion;
// a match unlocks that scan channel, repeated failures trigger a lockout.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ref_keys            - golden keys, channel c at [c*KEY_WIDTH +: KEY_WIDTH]
//   ref_keys_valid      - golden keys loaded and stable
//   lc_scan_allow       - lifecycle permits scan unlock
//   key_valid/key_ready - request handshake
//   key_chan, key_in    - target channel and candidate key
//   relock              - relock all channels
//   auth_pass/auth_fail - one-cycle result pulses
//   scan_unlock         - per-channel unlock (registered)
//   locked_out          - lockout in progress
//   fail_count          - consecutive failures so far

`include "mcse_def.svh"

module mcse_scan_auth_ctrl
   import mcse_pkg::*;
#(
   parameter int KEY_WIDTH      = `MCSE_KEY_WIDTH,
   parameter int NUM_CHAN       = `MCSE_NUM_CHAN,
   parameter int CMP_W          = `MCSE_CMP_W,
   parameter int MAX_ATTEMPTS   = `MCSE_MAX_ATTEMPTS,
   parameter int LOCKOUT_CYCLES = `MCSE_LOCKOUT_CYCLES,
   parameter int UNLOCK_TIMEOUT = `MCSE_UNLOCK_TIMEOUT
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_CHAN*KEY_WIDTH-1:0]         ref_keys,
   input  logic                                  ref_keys_valid,
   input  logic                                  lc_scan_allow,
   input  logic                                  key_valid,
   output logic                                  key_ready,
   input  logic [clog2_min1(NUM_CHAN)-1:0]       key_chan,
   input  logic [KEY_WIDTH-1:0]                  key_in,
   input  logic                                  relock,
   output logic                                  auth_pass,
   output logic                                  auth_fail,
   output logic [NUM_CHAN-1:0]                   scan_unlock,
   output logic                                  locked_out,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_count
);

   // KEY_WIDTH must be a whole number of CMP_W slices
   localparam int NUM_SLICES = KEY_WIDTH / CMP_W;
   localparam int CHAN_W     = clog2_min1(NUM_CHAN);
   localparam int IDX_W      = clog2_min1(NUM_SLICES);
   localparam int LOCK_W     = clog2_min1(LOCKOUT_CYCLES);
   localparam int TMR_W      = clog2_min1(UNLOCK_TIMEOUT + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLICES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(UNLOCK_TIMEOUT);

   mcse_state_e          state, state_next;
   mcse_result_e         result;
   logic [KEY_WIDTH-1:0] key_q;
   logic [CHAN_W-1:0]    chan_q;
   logic                 chan_bad_q;
   logic [IDX_W-1:0]     idx_q;
   logic [LOCK_W-1:0]    lock_cnt_q;
   logic [TMR_W-1:0]     tmr_q;
   logic                 accept, abort, cmp_en, cmp_clear, cmp_mismatch;
   logic                 last_attempt, unlock_clear, tmr_expire;
   logic [NUM_CHAN-1:0]  chan_onehot;

   logic [CMP_W-1:0] key_slice [NUM_SLICES];
   logic [CMP_W-1:0] ref_slice [NUM_CHAN][NUM_SLICES];

   for (genvar s = 0; s < NUM_SLICES; s++) begin : g_key_slice
      assign key_slice[s] = key_q[s*CMP_W +: CMP_W];
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_ref_chan
      for (genvar s = 0; s < NUM_SLICES; s++) begin : g_ref_slice
         assign ref_slice[c][s] = ref_keys[c*KEY_WIDTH + s*CMP_W +: CMP_W];
      end
   end

   // rst_n gates key_ready so it drops immediately during reset even when
   // the enabling inputs are held high
   assign key_ready    = rst_n & (state == IDLE) & ref_keys_valid & lc_scan_allow;
   assign accept       = key_valid & key_ready;
   assign locked_out   = (state == LOCKOUT);
   assign last_attempt = (int'(fail_count) + 1 >= MAX_ATTEMPTS);
   assign chan_onehot  = NUM_CHAN'(1) << chan_q;

   mcse_ct_compare #(
      .CMP_W    (CMP_W)
   ) u_compare (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (cmp_clear),
      .en       (cmp_en),
      .a        (key_slice[idx_q]),
      .b        (ref_slice[chan_q][idx_q]),
      .mismatch (cmp_mismatch)
   );

   // State register for the authentication sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode. CHECK always runs every slice before
   // moving on so the attempt length never reveals how much of the key
   // matched; only a lifecycle withdrawal cuts it short, silently.
   always_comb begin
      state_next = state;
      result     = RES_NONE;
      cmp_en     = 1'b0;
      cmp_clear  = 1'b0;
      abort      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cmp_clear  = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (!lc_scan_allow) begin
               abort      = 1'b1;
               cmp_clear  = 1'b1;
               state_next = IDLE;
            end else begin
               cmp_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_next = RESULT;
               end
            end
         end
         RESULT: begin
            cmp_clear = 1'b1;
            if (cmp_mismatch || chan_bad_q) begin
               result     = RES_FAIL;
               state_next = last_attempt ? LOCKOUT : IDLE;
            end else begin
               result     = RES_PASS;
               state_next = IDLE;
            end
         end
         LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, slice pointer, failure bookkeeping and lockout timer.
   // An out-of-range channel is remembered as a forced mismatch and the
   // compare runs against channel 0 so the timing stays the same.
   // Captured material is wiped as soon as the attempt ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q      <= '0;
         chan_q     <= '0;
         chan_bad_q <= 1'b0;
         idx_q      <= '0;
         fail_count <= '0;
         lock_cnt_q <= '0;
         auth_pass  <= 1'b0;
         auth_fail  <= 1'b0;
      end else begin
         auth_pass <= (result == RES_PASS);
         auth_fail <= (result == RES_FAIL);

         if (accept) begin
            key_q      <= key_in;
            chan_q     <= (int'(key_chan) < NUM_CHAN) ? key_chan : '0;
            chan_bad_q <= !(int'(key_chan) < NUM_CHAN);
            idx_q      <= '0;
         end else if (cmp_en) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         end

         if ((state == RESULT) || abort) begin
            key_q      <= '0;
            chan_q     <= '0;
            chan_bad_q <= 1'b0;
            idx_q      <= '0;
         end

         if (result == RES_PASS) begin
            fail_count <= '0;
         end else if (result == RES_FAIL) begin
            fail_count <= fail_count + 1'b1;
         end else if ((state == LOCKOUT) && (lock_cnt_q == '0)) begin
            fail_count <= '0;
         end

         if ((state != LOCKOUT) && (state_next == LOCKOUT)) begin
            lock_cnt_q <= LOCK_LOAD;
         end else if ((state == LOCKOUT) && (lock_cnt_q != '0)) begin
            lock_cnt_q <= lock_cnt_q - 1'b1;
         end
      end
   end

   // Per-channel unlock with one shared expiry timer. Relock, lifecycle
   // withdrawal and lockout override a coincident pass. The timer stays
   // at zero when UNLOCK_TIMEOUT is 0, so unlocks then never expire.
   assign unlock_clear = relock | ~lc_scan_allow | (state == LOCKOUT) | (state_next == LOCKOUT);
   assign tmr_expire   = (UNLOCK_TIMEOUT > 0) && (tmr_q == TMR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_unlock <= '0;
         tmr_q       <= '0;
      end else if (unlock_clear) begin
         scan_unlock <= '0;
         tmr_q       <= '0;
      end else if (result == RES_PASS) begin
         scan_unlock <= scan_unlock | chan_onehot;
         tmr_q       <= TMR_LOAD;
      end else if (tmr_expire) begin
         scan_unlock <= '0;
         tmr_q       <= '0;
      end else if (tmr_q != '0) begin
         tmr_q <= tmr_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_mcse_scan_auth_ctrl.sv
// tb_mcse_scan_auth_ctrl
// Directed bench for mcse_scan_auth_ctrl (UNLOCK_TIMEOUT=100, other
// parameters at their defaults). A transaction-level reference tracks
// pending requests by age, failure count, lockout time left and unlock
// timer, and is compared with the DUT on every falling edge; directed
// sequences add hand-computed literal expectations.

module tb_mcse_scan_auth_ctrl;

   localparam int KW = 128;
   localparam int NC = 4;
   localparam int CW = 32;
   localparam int MA = 3;
   localparam int LC = 1024;
   localparam int UT = 100;
   localparam int NS = KW / CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NC*KW-1:0] ref_keys = '0;
   logic          ref_keys_valid = 1'b0;
   logic          lc_scan_allow = 1'b0;
   logic          key_valid = 1'b0;
   logic [1:0]    key_chan = '0;
   logic [KW-1:0] key_in = '0;
   logic          relock = 1'b0;
   logic          key_ready, auth_pass, auth_fail, locked_out;
   logic [NC-1:0] scan_unlock;
   logic [1:0]    fail_count;

   int checks = 0;
   int errors = 0;
   logic [KW-1:0] ref_arr [NC];

   mcse_scan_auth_ctrl #(
      .KEY_WIDTH      (KW),
      .NUM_CHAN       (NC),
      .CMP_W          (CW),
      .MAX_ATTEMPTS   (MA),
      .LOCKOUT_CYCLES (LC),
      .UNLOCK_TIMEOUT (UT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ref_keys       (ref_keys),
      .ref_keys_valid (ref_keys_valid),
      .lc_scan_allow  (lc_scan_allow),
      .key_valid      (key_valid),
      .key_ready      (key_ready),
      .key_chan       (key_chan),
      .key_in         (key_in),
      .relock         (relock),
      .auth_pass      (auth_pass),
      .auth_fail      (auth_fail),
      .scan_unlock    (scan_unlock),
      .locked_out     (locked_out),
      .fail_count     (fail_count)
   );

   always #5 clk = ~clk;

   // Reference state: one request in flight, aged in clock edges
   bit          m_pending = 0;
   int          m_age = 0;
   bit          m_match = 0;
   int          m_chan = 0;
   int          m_fails = 0;
   int          m_lock_left = 0;
   int          m_timer = 0;
   logic [NC-1:0] m_unlock = '0;
   bit          m_pass = 0;
   bit          m_fail = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference update on each edge: whole-key equality decides the
   // outcome, which lands NS+1 edges after acceptance unless the
   // lifecycle permission drops during the NS compare edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending = 0; m_age = 0; m_match = 0; m_chan = 0; m_fails = 0;
         m_lock_left = 0; m_timer = 0; m_unlock = '0; m_pass = 0; m_fail = 0;
      end else begin
         bit ready_before;
         bit result_now;
         ready_before = !m_pending && (m_lock_left == 0) && ref_keys_valid && lc_scan_allow;
         result_now = 0;
         m_pass = 0;
         m_fail = 0;
         if (m_pending) begin
            m_age++;
            if (m_age <= NS && !lc_scan_allow) m_pending = 0;
            else if (m_age == NS + 1) begin
               m_pending = 0;
               result_now = 1;
            end
         end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
         end
         if (result_now) begin
            if (m_match) begin
               m_pass = 1;
               m_fails = 0;
            end else begin
               m_fail = 1;
               m_fails++;
               if (m_fails >= MA) m_lock_left = LC;
            end
         end
         if (ready_before && key_valid) begin
            m_pending = 1;
            m_age = 0;
            m_chan = int'(key_chan);
            m_match = (m_chan < NC) && (key_in == ref_arr[m_chan]);
         end
         if (relock || !lc_scan_allow || m_lock_left > 0) begin
            m_unlock = '0;
            m_timer = 0;
         end else if (m_pass) begin
            m_unlock[m_chan] = 1'b1;
            m_timer = UT;
         end else if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) m_unlock = '0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the reference
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("cyc_key_ready", 32'(key_ready),
                     32'(!m_pending && m_lock_left == 0 && ref_keys_valid && lc_scan_allow));
         checkOutput("cyc_auth_pass", 32'(auth_pass), 32'(m_pass));
         checkOutput("cyc_auth_fail", 32'(auth_fail), 32'(m_fail));
         checkOutput("cyc_scan_unlock", 32'(scan_unlock), 32'(m_unlock));
         checkOutput("cyc_locked_out", 32'(locked_out), 32'(m_lock_left > 0));
         checkOutput("cyc_fail_count", 32'(fail_count), 32'(m_fails));
      end
   end

   // Present a request and return just after the accepting edge
   task automatic applyStimulus(input logic [1:0] chan, input logic [KW-1:0] key);
      bit ok;
      ok = 0;
      key_chan = chan;
      key_in = key;
      key_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (key_ready) begin
            @(posedge clk);
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      #1;
      key_valid = 1'b0;
      key_in = '0;
      if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   // Edges from acceptance until a result pulse is seen
   task automatic waitResult(output int lat, output logic passed);
      lat = 0;
      passed = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (auth_pass || auth_fail) begin
            lat = i;
            passed = auth_pass;
            break;
         end
      end
      if (lat == 0) checkOutput("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic runRequest(input logic [1:0] chan, input logic [KW-1:0] key,
                             output int lat, output logic passed);
      applyStimulus(chan, key);
      waitResult(lat, passed);
   endtask

   // Edges until cond signal drops, bounded
   task automatic countUnlockEdges(output int cnt);
      cnt = 0;
      for (int i = 1; i <= 400; i++) begin
         @(posedge clk);
         #1;
         if (scan_unlock == '0) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_key_ready"}, 32'(key_ready), 32'd0);
      checkOutput({tag, "_auth_pass"}, 32'(auth_pass), 32'd0);
      checkOutput({tag, "_auth_fail"}, 32'(auth_fail), 32'd0);
      checkOutput({tag, "_scan_unlock"}, 32'(scan_unlock), 32'd0);
      checkOutput({tag, "_locked_out"}, 32'(locked_out), 32'd0);
      checkOutput({tag, "_fail_count"}, 32'(fail_count), 32'd0);
   endtask

   task automatic threeFails();
      int lat;
      logic p;
      for (int n = 0; n < MA; n++) begin
         runRequest(2'(n), ref_arr[n] ^ {KW{1'b1}}, lat, p);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int cnt;
      int pulses;
      logic p;
      logic [KW-1:0] k;

      for (int c = 0; c < NC; c++) begin
         ref_arr[c] = {$urandom, $urandom, $urandom, $urandom};
         ref_keys[c*KW +: KW] = ref_arr[c];
      end
      ref_keys_valid = 1'b1;
      lc_scan_allow = 1'b1;
      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] correct key on channel 2");
      runRequest(2'd2, ref_arr[2], lat, p);
      checkOutput("pass_latency", 32'(lat), 32'd5);
      checkOutput("pass_pulse", 32'(p), 32'd1);
      checkOutput("pass_unlock", 32'(scan_unlock), 32'b0100);

      $display("[TB] MSB-only and LSB-only wrong keys, then lockout");
      k = ref_arr[1];
      k[KW-1] = ~k[KW-1];
      runRequest(2'd1, k, lat, p);
      checkOutput("msb_fail_latency", 32'(lat), 32'd5);
      checkOutput("msb_fail_pulse", 32'(p), 32'd0);
      checkOutput("fail_count_1", 32'(fail_count), 32'd1);
      k = ref_arr[1];
      k[0] = ~k[0];
      runRequest(2'd1, k, lat, p);
      checkOutput("lsb_fail_latency", 32'(lat), 32'd5);
      checkOutput("fail_count_2", 32'(fail_count), 32'd2);
      runRequest(2'd0, ref_arr[0] ^ 128'h1_0000, lat, p);
      checkOutput("fail_count_3", 32'(fail_count), 32'd3);
      checkOutput("lockout_asserted", 32'(locked_out), 32'd1);
      checkOutput("lockout_not_ready", 32'(key_ready), 32'd0);
      checkOutput("lockout_unlock_clear", 32'(scan_unlock), 32'd0);
      cnt = 1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (!locked_out) break;
         cnt++;
      end
      checkOutput("lockout_cycles", 32'(cnt), 32'd1024);
      checkOutput("post_lockout_fail_count", 32'(fail_count), 32'd0);
      checkOutput("post_lockout_ready", 32'(key_ready), 32'd1);

      $display("[TB] unlock timeout and extension");
      runRequest(2'd3, ref_arr[3], lat, p);
      checkOutput("timeout_unlock", 32'(scan_unlock), 32'b1000);
      countUnlockEdges(cnt);
      checkOutput("timeout_cycles", 32'(cnt), 32'd100);
      runRequest(2'd0, ref_arr[0], lat, p);
      repeat (44) @(posedge clk);
      #1;
      runRequest(2'd1, ref_arr[1], lat, p);
      checkOutput("extend_unlock", 32'(scan_unlock), 32'b0011);
      countUnlockEdges(cnt);
      checkOutput("extend_total_cycles", 32'(cnt + 50), 32'd150);

      $display("[TB] lifecycle abort during compare");
      runRequest(2'd3, ref_arr[3] ^ 128'h8, lat, p);
      checkOutput("abort_pre_fail_count", 32'(fail_count), 32'd1);
      applyStimulus(2'd0, ref_arr[0]);
      @(posedge clk);
      #1;
      lc_scan_allow = 1'b0;
      @(posedge clk);
      #1;
      lc_scan_allow = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (auth_pass || auth_fail) pulses++;
      end
      checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
      checkOutput("abort_fail_count", 32'(fail_count), 32'd1);
      checkOutput("abort_ready", 32'(key_ready), 32'd1);

      $display("[TB] relock coincident with a pass");
      applyStimulus(2'd2, ref_arr[2]);
      repeat (4) @(posedge clk);
      #1;
      relock = 1'b1;
      @(posedge clk);
      #1;
      relock = 1'b0;
      checkOutput("relock_unlock", 32'(scan_unlock), 32'd0);
      checkOutput("relock_fail_count", 32'(fail_count), 32'd0);

      $display("[TB] reset asserted during lockout");
      runRequest(2'd0, ref_arr[0], lat, p);
      checkOutput("pre_reset_unlock", 32'(scan_unlock), 32'b0001);
      threeFails();
      checkOutput("pre_reset_locked", 32'(locked_out), 32'd1);
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("lockout_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("after_reset_ready", 32'(key_ready), 32'd1);
      checkOutput("after_reset_locked", 32'(locked_out), 32'd0);
      checkOutput("after_reset_unlock", 32'(scan_unlock), 32'd0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
